// File: rtl/rvfi_pkg.sv
// rvfi_pkg: retirement packet layout shared by the retire buffer, its interface and checkers
// Exports REG_AW (register address width), RVFI_PKT_W and rvfi_pkt_t.
package rvfi_pkg;
   localparam int REG_AW = 5;
   localparam int RVFI_PKT_W = 207;
   typedef struct packed {
      logic [63:0]       order;
      logic [31:0]       insn;
      logic [REG_AW-1:0] rd_addr;
      logic [31:0]       rd_wdata;
      logic [REG_AW-1:0] rs1_addr;
      logic [31:0]       rs1_rdata;
      logic [REG_AW-1:0] rs2_addr;
      logic [31:0]       rs2_rdata;
   } rvfi_pkt_t;
endpackage

// File: rtl/rvfi_retire_buf_if.sv
// rvfi_retire_buf_if: RVFI retirement inputs plus the buffered valid/ready packet output
// master: retirement source and packet consumer; slave: the retire buffer.
interface rvfi_retire_buf_if;
   import rvfi_pkg::*;
   logic              rvfi_valid;
   logic [63:0]       rvfi_order;
   logic [31:0]       rvfi_insn;
   logic [REG_AW-1:0] rvfi_rd_addr;
   logic [31:0]       rvfi_rd_wdata;
   logic [REG_AW-1:0] rvfi_rs1_addr;
   logic [31:0]       rvfi_rs1_rdata;
   logic [REG_AW-1:0] rvfi_rs2_addr;
   logic [31:0]       rvfi_rs2_rdata;
   logic              out_valid_o;
   logic              out_ready_i;
   rvfi_pkt_t         out_pkt_o;
   modport master (
      output rvfi_valid, rvfi_order, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
             rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr, rvfi_rs2_rdata, out_ready_i,
      input  out_valid_o, out_pkt_o
   );
   modport slave (
      input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
             rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr, rvfi_rs2_rdata, out_ready_i,
      output out_valid_o, out_pkt_o
   );
endinterface

// File: rtl/rvfi_retire_buf_fifo.sv
// sync_fifo: W-bit x DEPTH synchronous FIFO, head read combinationally from storage
// Ports: clk_i, rst_i, push/din (write), pop (advance head), dout (head), level, full.
// Callers pre-qualify push/pop; push while full is legal only together with pop.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [LW-1:0] wp, rp;
   assign dout = mem[rp[AW-1:0]];
   assign full = level == LW'(DEPTH);
   // when full, wp and rp share low bits: the push overwrites the slot being popped
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) mem[wp[AW-1:0]] <= din;
         wp    <= wp + LW'(push);
         rp    <= rp + LW'(pop);
         level <= level + LW'(push) - LW'(pop);
      end
   end
endmodule

// File: rtl/rvfi_retire_buf.sv
// rvfi_retire_buf: buffers RVFI retirements for checkers, flags drops, order gaps and x0 writes
// Ports: clk_i, rst_i, bus (slave: RVFI in, out_valid_o/out_ready_i/out_pkt_o),
// level_o occupancy, overflow_o/drop_cnt_o drop status, order_err_o, x0_err_o sticky errors.
module rvfi_retire_buf
   import rvfi_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   rvfi_retire_buf_if.slave       bus,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   overflow_o,
   output logic [CNT_W-1:0]       drop_cnt_o,
   output logic                   order_err_o,
   output logic                   x0_err_o
);
   rvfi_pkt_t   in_pkt;
   logic        full, push, pop, drop, synced;
   logic [63:0] exp_order;
   assign in_pkt = '{order: bus.rvfi_order, insn: bus.rvfi_insn,
                     rd_addr: bus.rvfi_rd_addr, rd_wdata: bus.rvfi_rd_wdata,
                     rs1_addr: bus.rvfi_rs1_addr, rs1_rdata: bus.rvfi_rs1_rdata,
                     rs2_addr: bus.rvfi_rs2_addr, rs2_rdata: bus.rvfi_rs2_rdata};
   assign bus.out_valid_o = level_o != '0;
   assign pop  = bus.out_valid_o && bus.out_ready_i;
   assign push = bus.rvfi_valid && (!full || pop);
   assign drop = bus.rvfi_valid && full && !pop;
   sync_fifo #(.W(RVFI_PKT_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .din   (in_pkt),
      .dout  (bus.out_pkt_o),
      .level (level_o),
      .full  (full)
   );
   // order tracking and x0 check see every retirement, dropped or not
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overflow_o  <= 1'b0;
         drop_cnt_o  <= '0;
         order_err_o <= 1'b0;
         x0_err_o    <= 1'b0;
         synced      <= 1'b0;
         exp_order   <= '0;
      end else begin
         if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
         end
         if (bus.rvfi_valid) begin
            synced    <= 1'b1;
            exp_order <= bus.rvfi_order + 64'd1;
            if (synced && bus.rvfi_order != exp_order) order_err_o <= 1'b1;
            if (bus.rvfi_rd_addr == '0 && bus.rvfi_rd_wdata != '0) x0_err_o <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rvfi_retire_buf.sv
// tb_rvfi_retire_buf: scoreboard bench for rvfi_retire_buf with directed and random retirements
module tb_rvfi_retire_buf;
   import rvfi_pkg::*;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [LW-1:0]    level;
   logic             overflow, order_err, x0_err;
   logic [CNT_W-1:0] drop_cnt;
   rvfi_retire_buf_if bus ();
   rvfi_retire_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus.slave),
      .level_o     (level),
      .overflow_o  (overflow),
      .drop_cnt_o  (drop_cnt),
      .order_err_o (order_err),
      .x0_err_o    (x0_err)
   );
   always #5 clk = ~clk;
   int          checks = 0;
   int          errors = 0;
   rvfi_pkt_t   sb[$];
   int          m_level = 0;
   int          m_drops = 0;
   logic        m_ovf = 1'b0;
   logic        m_oerr = 1'b0;
   logic        m_x0 = 1'b0;
   logic        m_synced = 1'b0;
   logic [63:0] m_next = '0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic chk_pkt(input string name, input rvfi_pkt_t act, input rvfi_pkt_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic rvfi_pkt_t mk(input logic [63:0] o, input logic [4:0] rd, input logic [31:0] wd);
      rvfi_pkt_t p;
      p.order     = o;
      p.insn      = $urandom;
      p.rd_addr   = rd;
      p.rd_wdata  = wd;
      p.rs1_addr  = 5'($urandom);
      p.rs1_rdata = $urandom;
      p.rs2_addr  = 5'($urandom);
      p.rs2_rdata = $urandom;
      return p;
   endfunction
   task automatic check_state();
      chk("level", 64'(level), 64'(m_level));
      chk("out_valid", 64'(bus.out_valid_o), 64'(m_level > 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("order_err", 64'(order_err), 64'(m_oerr));
      chk("x0_err", 64'(x0_err), 64'(m_x0));
   endtask
   task automatic drive(input logic v, input rvfi_pkt_t p, input logic r);
      bus.rvfi_valid     = v;
      bus.rvfi_order     = p.order;
      bus.rvfi_insn      = p.insn;
      bus.rvfi_rd_addr   = p.rd_addr;
      bus.rvfi_rd_wdata  = p.rd_wdata;
      bus.rvfi_rs1_addr  = p.rs1_addr;
      bus.rvfi_rs1_rdata = p.rs1_rdata;
      bus.rvfi_rs2_addr  = p.rs2_addr;
      bus.rvfi_rs2_rdata = p.rs2_rdata;
      bus.out_ready_i    = r;
   endtask
   // one clock of stimulus; the model predicts the state after the coming edge
   task automatic step(input logic v, input rvfi_pkt_t p, input logic r);
      bit pop_m, push_m;
      @(negedge clk);
      check_state();
      drive(v, p, r);
      pop_m  = m_level > 0 && r;
      push_m = v && (m_level < DEPTH || pop_m);
      if (push_m) sb.push_back(p);
      if (v && !push_m) begin
         m_ovf = 1'b1;
         if (m_drops < (2 ** CNT_W) - 1) m_drops++;
      end
      if (v) begin
         if (m_synced && p.order != m_next) m_oerr = 1'b1;
         m_synced = 1'b1;
         m_next   = p.order + 64'd1;
         if (p.rd_addr == 5'd0 && p.rd_wdata != 32'd0) m_x0 = 1'b1;
      end
      m_level += int'(push_m) - int'(pop_m);
   endtask
   task automatic idle(input int n, input logic r);
      repeat (n) step(1'b0, '0, r);
   endtask
   // park with ready low so the extra negedge leaves DUT and model untouched
   task automatic hold();
      step(1'b0, '0, 1'b0);
      @(negedge clk);
      check_state();
   endtask
   task automatic do_reset();
      @(negedge clk);
      check_state();
      rst = 1'b1;
      drive(1'b1, mk(64'd77, 5'd0, 32'hdead), 1'b1);
      bus.out_ready_i = 1'b0;
      sb.delete();
      m_level = 0;
      m_drops = 0;
      m_ovf = 1'b0;
      m_oerr = 1'b0;
      m_x0 = 1'b0;
      m_synced = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, '0, 1'b0);
      check_state();
      chk_pkt("reset_pkt", bus.out_pkt_o, '0);
   endtask
   initial begin : monitor
      rvfi_pkt_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pkt: unexpected packet %h, none expected", bus.out_pkt_o);
            end else begin
               e = sb.pop_front();
               chk_pkt("pkt", bus.out_pkt_o, e);
            end
         end
      end
   end
   initial begin : stim
      logic [63:0] nxt;
      int          bias;
      drive(1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, mk(64'(10 + i), 5'($urandom_range(1, 31)), $urandom), 1'b1);
         idle(1, 1'b1);
      end
      hold();
      chk("tp1_flags", 64'({overflow, order_err, x0_err}), 64'd0);
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, mk(64'(i), 5'd3, $urandom), 1'b0);
      hold();
      chk("tp2_level", 64'(level), 64'd4);
      chk("tp2_overflow", 64'(overflow), 64'd1);
      chk("tp2_drops", 64'(drop_cnt), 64'd2);
      idle(6, 1'b1);
      hold();
      chk("tp2_drained", 64'(sb.size()), 64'd0);
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, mk(64'(i), 5'd1, $urandom), 1'b0);
      for (int i = 4; i < 9; i++) step(1'b1, mk(64'(i), 5'd1, $urandom), 1'b1);
      hold();
      chk("tp3_level", 64'(level), 64'd4);
      chk("tp3_drops", 64'(drop_cnt), 64'd0);
      idle(6, 1'b1);
      do_reset();
      step(1'b1, mk(64'd5, 5'd2, $urandom), 1'b0);
      step(1'b1, mk(64'd6, 5'd2, $urandom), 1'b0);
      hold();
      chk("tp4_no_err_yet", 64'(order_err), 64'd0);
      step(1'b1, mk(64'd8, 5'd2, $urandom), 1'b0);
      step(1'b1, mk(64'd9, 5'd2, $urandom), 1'b0);
      hold();
      chk("tp4_order_err", 64'(order_err), 64'd1);
      chk("tp4_level", 64'(level), 64'd4);
      idle(6, 1'b1);
      do_reset();
      step(1'b1, mk(64'd40, 5'd0, 32'h1), 1'b1);
      idle(3, 1'b1);
      hold();
      chk("tp5_x0", 64'(x0_err), 64'd1);
      do_reset();
      step(1'b1, mk(64'd1, 5'd4, $urandom), 1'b0);
      step(1'b1, mk(64'd2, 5'd0, 32'h5), 1'b0);
      step(1'b1, mk(64'd7, 5'd4, $urandom), 1'b0);
      hold();
      chk("tp6_level", 64'(level), 64'd3);
      chk("tp6_flags", 64'({order_err, x0_err}), 64'h3);
      do_reset();
      chk("tp6_rst_level", 64'(level), 64'd0);
      step(1'b1, mk(64'd1000, 5'd6, $urandom), 1'b1);
      idle(2, 1'b1);
      hold();
      chk("tp6_resync", 64'(order_err), 64'd0);
      do_reset();
      nxt  = 64'($urandom);
      bias = 50;
      for (int c = 0; c < 3000; c++) begin
         rvfi_pkt_t p;
         logic      v;
         if (c % 200 == 0) bias = (c / 200) % 3 == 0 ? 10 : (c / 200) % 3 == 1 ? 50 : 90;
         if ($urandom_range(0, 39) == 0) nxt = {$urandom, $urandom};
         v = $urandom_range(0, 3) != 0;
         p = mk(nxt, $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom),
                $urandom_range(0, 1) == 0 ? 32'd0 : $urandom);
         if (v) nxt = nxt + 64'd1;
         step(v, p, 1'($urandom_range(0, 99) < bias));
      end
      idle(DEPTH + 4, 1'b1);
      hold();
      chk("final_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rvfi_retire_buf.md
Name: rvfi_retire_buf

Overview:
- Capture stage between the core's RVFI retirement outputs in ibex_top and the downstream register-consistency checkers.
- Registers every retired-instruction packet into a small FIFO and presents the packets on a valid/ready interface.
- Lets checkers stall without losing retirements, and flags any retirements that are lost.
- Checks that rvfi_order increments by exactly one per retirement, and that no retirement writes a non-zero value to x0.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 16, width of the drop counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
rvfi_valid  in  1  retirement strobe
rvfi_order  in  64  retirement sequence number
rvfi_insn  in  32  retired instruction word
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
rvfi_rs1_addr  in  5  source 1 register
rvfi_rs1_rdata  in  32  source 1 read data
rvfi_rs2_addr  in  5  source 2 register
rvfi_rs2_rdata  in  32  source 2 read data
out_valid_o  out  1  head packet valid
out_ready_i  in  1  consumer accepts head packet
out_pkt_o  out  207  head packet {order, insn, rd_addr, rd_wdata, rs1_addr, rs1_rdata, rs2_addr, rs2_rdata}
level_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: at least one packet dropped
drop_cnt_o  out  CNT_W  dropped packet count, saturating
order_err_o  out  1  sticky: order discontinuity seen
x0_err_o  out  1  sticky: rd_addr==0 with rd_wdata!=0

Behaviour:
- Reset (rst_i high at a clk_i edge) clears all outputs and state:
  - level_o=0, out_valid_o=0, out_pkt_o=0
  - all sticky flags 0, drop_cnt_o=0
  - order tracker set to "unsynced"
- Reset mid-operation discards the buffered packets. Inputs in the reset cycle are ignored.
- Push condition: rvfi_valid && (!full || pop).
- Pop condition: out_valid_o && out_ready_i.
- Simultaneous push and pop:
  - When full: the push is accepted and level_o is unchanged.
  - When empty: only the push occurs. There is no bypass, so pop is impossible.
- Latency: a packet pushed at edge t has out_valid_o=1 from cycle t+1. Minimum latency is one cycle.
- out_pkt_o always reflects the head entry. It is don't-care while out_valid_o=0.
- Pointers are $clog2(DEPTH)+1 bits wide, and the MSB distinguishes full from empty.
  - Wrap-around is natural modulo 2*DEPTH.
  - full = level_o==DEPTH; empty = level_o==0.
- Drop: rvfi_valid while full with no pop.
  - The packet is discarded and overflow_o is set.
  - drop_cnt_o increments and saturates at 2^CNT_W-1.
- Order tracker runs on every rvfi_valid, including dropped packets:
  - Unsynced: load expected = rvfi_order+1 and go to synced.
  - Synced, rvfi_order==expected: expected += 1 (64-bit wrap).
  - Synced, rvfi_order!=expected: set order_err_o and resync to expected = rvfi_order+1.
- x0 check runs on every rvfi_valid:
  - rd_addr==0 && rd_wdata!=0 sets x0_err_o.
  - The packet is still buffered unchanged.
- Sticky flags clear only on reset.
- All outputs are registered except out_pkt_o, which is a RAM read at the head pointer.

Decomposition:
- Package rvfi_pkg:
  - rvfi_pkt_t packed struct, with field order as listed for out_pkt_o.
  - RVFI_PKT_W=207.
  - Register-address width constant of 5.
- Sub-module sync_fifo, parameterised by width and depth:
  - Owns the storage, pointers and level, and is instantiated once.
  - Accepts push-on-full-with-pop.
- Top-level rvfi_retire_buf holds the drop counter, the order tracker and the x0 check.

Test Plan:
- Reset, then 3 retirements with order 10,11,12 and out_ready_i=1 -> out_valid_o rises one cycle after each; packets emerge in order; level_o max 1; all flags 0.
- out_ready_i=0 with 6 retirements at DEPTH=4 -> level_o=4; overflow_o=1; drop_cnt_o=2; after ready, exactly orders 0..3 emerge.
- Full FIFO, rvfi_valid and out_ready_i both high for 5 cycles -> no drops; level_o stays 4; FIFO order preserved across pointer wrap.
- Orders 5,6,8,9 -> order_err_o=1 after the third retirement; no further error on 9 (resynced); all 4 packets buffered.
- Retirement with rd_addr=0, rd_wdata=32'h1 -> x0_err_o=1; packet emerges unchanged.
- rst_i asserted with level_o=3 and flags set -> next cycle level_o=0, out_valid_o=0, flags 0, drop_cnt_o=0; first subsequent order of any value gives no order_err_o.
